voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Polyphony scheduler sitting between the note decoder and a bank of NUM_VOICES phase accumulators.
- Accepts note-on and note-off events over a valid/ready handshake.
- Assigns each note-on to a voice and releases voices on note-off.
- Per voice, drives the note number that selects that accumulator's phase increment, plus a one-cycle restart pulse used as that accumulator's phase reset.

Parameters:
- NUM_VOICES, 4: number of phase accumulators managed; must be ≥2.
- STAMP_W, 16: width of the allocation age stamp.

Ports:
- clk_in  input  1  system clock (100 MHz)
- rst_in  input  1  synchronous, active-low reset
- event_valid_in  input  1  event present
- event_ready_out  output  1  allocator can accept an event
- event_on_in  input  1  1 = note-on, 0 = note-off
- event_note_in  input  8  MIDI note number
- voice_note_out  output  8*NUM_VOICES  note per voice; voice i occupies bits [8i+7:8i]; 0 = silent
- voice_active_out  output  NUM_VOICES  voice i currently holds a note
- voice_restart_out  output  NUM_VOICES  one-cycle pulse; restart voice i's phase
- drop_out  output  1  one-cycle pulse; a note-on was discarded

Behaviour:
- Reset (rst_in==0 at a clock edge):
  - All voice_note_out = 0; voice_active_out = 0; voice_restart_out = 0; drop_out = 0; event_ready_out = 1.
  - Stamp counter and per-voice stamps = 0; FSM = IDLE.
  - Reset mid-scan abandons the event without any voice update.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE:
  - event_ready_out = 1.
  - Event accepted on an edge where event_valid_in && event_ready_out. Latch on/note, clear scan results, go to SCAN with idx = 0.
- SCAN:
  - event_ready_out = 0. Examine voice idx once per cycle for NUM_VOICES cycles, then go to COMMIT.
  - Tracks three results:
    - match_idx: lowest active voice with note == latched note.
    - free_idx: lowest inactive voice.
    - old_idx: active voice with the largest (stamp_ctr − stamp[i]) mod 2^STAMP_W; ties go to the lowest index.
- COMMIT (one cycle, event_ready_out = 0), then back to IDLE:
  - note-on with a match: retrigger match_idx. Pulse its restart; update its stamp.
  - note-on, no match, free voice found: voice_note[free] = note, active = 1, pulse restart, stamp[free] = stamp_ctr, stamp_ctr += 1 (wraps modulo 2^STAMP_W).
  - note-on, all voices busy: see Optional Feature.
  - note-off with a match: voice_note = 0, active = 0, no restart pulse.
  - note-off without a match: no change.
  - note 0 is treated as a normal note number.
- Latency:
  - Accept at edge k; outputs change at edge k+NUM_VOICES+1.
  - voice_restart_out and drop_out are high only for the cycle following the COMMIT edge.
  - event_ready_out returns high after the COMMIT edge.
  - Back-to-back event throughput: one event per NUM_VOICES+2 cycles.
- Voice outputs are registered and hold their values between commits.
- event_note_in and event_on_in are ignored while event_ready_out = 0.

Optional Feature:
- Macro: VOICE_STEAL_EN.
- Defined: a note-on with all voices busy steals old_idx. That voice gets the new note, restart pulse, and a new stamp; drop_out stays 0.
- Undefined: the note-on is discarded; drop_out pulses for one cycle and no voice changes.

Decomposition:
- Package synth_pkg holds:
  - typedef note_t (logic [7:0]) and constant NOTE_SILENT = 8'd0.
  - typedef alloc_state_t enum {IDLE, SCAN, COMMIT}.
- One sub-module, voice_scan_unit: sequential comparator that accumulates match_idx/free_idx/old_idx across the scan.

Test Plan:
- Reset, then note-on 60 → after NUM_VOICES+1 cycles, voice 0 note = 60, active = 4'b0001, restart pulse on voice 0 only.
- Note-ons 60, 62, 64 then note-off 62 → voice 1 note = 0, active = 4'b0101; a following note-on 67 lands on voice 1.
- Note-on 60 twice → single voice used, second event pulses restart[0]; active = 4'b0001.
- Fill with 60, 62, 64, 65, then note-on 72:
  - With VOICE_STEAL_EN: voice 0 = 72.
  - Without: drop_out pulses once and voices are unchanged.
- Note-off 71 while idle → no output change; event_ready_out deasserts for NUM_VOICES+1 cycles then reasserts.
- Drive rst_in = 0 during SCAN → all outputs zero next cycle, pending event lost; event_ready_out = 1.

Source files
------------

// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
// Module : synth_pkg
// Shared note and allocator-state types for the polyphony voice allocator.
// Rev    : 1.0 - initial release
// ============================================================================
package synth_pkg;

    typedef logic [7:0] note_t;

    localparam note_t NOTE_SILENT = 8'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } alloc_state_t;

endpackage
`default_nettype wire

// File: rtl/voice_scan_unit.sv
`default_nettype none
// ============================================================================
// Module : voice_scan_unit
// Sequential comparator that accumulates match/free/oldest voice indices while
// the allocator walks the voices one per cycle in ascending index order.
// Rev    : 1.0 - initial release
// ============================================================================
module voice_scan_unit
    import synth_pkg::*;
#(
    parameter int IDX_W   = 2,
    parameter int STAMP_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_en,
    input  logic [IDX_W-1:0]   i_idx,
    input  logic               i_active,
    input  note_t              i_note,
    input  note_t              i_target,
    input  logic [STAMP_W-1:0] i_age,
    output logic               o_match_found,
    output logic [IDX_W-1:0]   o_match_idx,
    output logic               o_free_found,
    output logic [IDX_W-1:0]   o_free_idx,
    output logic [IDX_W-1:0]   o_old_idx
);

    logic               r_match_found;
    logic [IDX_W-1:0]   r_match_idx;
    logic               r_free_found;
    logic [IDX_W-1:0]   r_free_idx;
    logic               r_old_found;
    logic [IDX_W-1:0]   r_old_idx;
    logic [STAMP_W-1:0] r_old_age;

    // Voices arrive in ascending order, so "first hit wins" and a strict
    // greater-than on age both resolve ties toward the lowest index.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_old_found   <= 1'b0;
            r_old_idx     <= '0;
            r_old_age     <= '0;
        end else if (i_en) begin
            if (i_active && (i_note == i_target) && !r_match_found) begin
                r_match_found <= 1'b1;
                r_match_idx   <= i_idx;
            end
            if (!i_active && !r_free_found) begin
                r_free_found <= 1'b1;
                r_free_idx   <= i_idx;
            end
            if (i_active && (!r_old_found || (i_age > r_old_age))) begin
                r_old_found <= 1'b1;
                r_old_idx   <= i_idx;
                r_old_age   <= i_age;
            end
        end
    end

    assign o_match_found = r_match_found;
    assign o_match_idx   = r_match_idx;
    assign o_free_found  = r_free_found;
    assign o_free_idx    = r_free_idx;
    assign o_old_idx     = r_old_idx;

endmodule
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module : voice_allocator
// Polyphony scheduler: assigns note-on events to voices, releases them on
// note-off. Define VOICE_STEAL_EN to steal the oldest voice when all are busy.
// Rev    : 1.0 - initial release
// ============================================================================
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int STAMP_W    = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    event_valid_in,
    output logic                    event_ready_out,
    input  logic                    event_on_in,
    input  logic [7:0]              event_note_in,
    output logic [8*NUM_VOICES-1:0] voice_note_out,
    output logic [NUM_VOICES-1:0]   voice_active_out,
    output logic [NUM_VOICES-1:0]   voice_restart_out,
    output logic                    drop_out
);

    localparam int                 c_IDX_W    = $clog2(NUM_VOICES);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_VOICES - 1);

    alloc_state_t                r_state;
    logic [c_IDX_W-1:0]          r_idx;
    logic                        r_on;
    note_t                       r_note;
    logic                        r_ready;
    logic                        r_drop;
    note_t [NUM_VOICES-1:0]      r_voice_note;
    logic [NUM_VOICES-1:0]       r_active;
    logic [NUM_VOICES-1:0]       r_restart;
    logic [STAMP_W-1:0]          r_stamp_ctr;
    logic [STAMP_W-1:0]          r_stamp [NUM_VOICES];

    logic                        w_accept;
    logic                        w_scan_en;
    logic [STAMP_W-1:0]          w_sel_age;
    logic                        w_match_found;
    logic [c_IDX_W-1:0]          w_match_idx;
    logic                        w_free_found;
    logic [c_IDX_W-1:0]          w_free_idx;
    logic [c_IDX_W-1:0]          w_old_idx;
    logic                        w_take;
    logic [c_IDX_W-1:0]          w_target_idx;

    assign w_accept  = event_valid_in && r_ready;
    assign w_scan_en = (r_state == SCAN);
    // Modular age keeps the oldest-voice choice correct across stamp wrap.
    assign w_sel_age = r_stamp_ctr - r_stamp[r_idx];

    voice_scan_unit #(
        .IDX_W   (c_IDX_W),
        .STAMP_W (STAMP_W)
    ) u_scan (
        .clk           (clk_in),
        .rst_n         (rst_in),
        .i_clear       (w_accept),
        .i_en          (w_scan_en),
        .i_idx         (r_idx),
        .i_active      (r_active[r_idx]),
        .i_note        (r_voice_note[r_idx]),
        .i_target      (r_note),
        .i_age         (w_sel_age),
        .o_match_found (w_match_found),
        .o_match_idx   (w_match_idx),
        .o_free_found  (w_free_found),
        .o_free_idx    (w_free_idx),
        .o_old_idx     (w_old_idx)
    );

    always_comb begin
        w_target_idx = w_match_found ? w_match_idx : w_free_idx;
        w_take       = r_on && (w_match_found || w_free_found);
`ifdef VOICE_STEAL_EN
        if (!w_match_found && !w_free_found) begin
            w_target_idx = w_old_idx;
            w_take       = r_on;
        end
`endif
    end

`ifndef VOICE_STEAL_EN
    logic w_unused_old;
    assign w_unused_old = &{1'b0, w_old_idx};
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_on         <= 1'b0;
            r_note       <= NOTE_SILENT;
            r_ready      <= 1'b1;
            r_drop       <= 1'b0;
            r_restart    <= '0;
            r_active     <= '0;
            r_voice_note <= '0;
            r_stamp_ctr  <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_stamp[i] <= '0;
            end
        end else begin
            r_restart <= '0;
            r_drop    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_on    <= event_on_in;
                        r_note  <= event_note_in;
                        r_idx   <= '0;
                        r_ready <= 1'b0;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (w_take) begin
                        r_voice_note[w_target_idx] <= r_note;
                        r_active[w_target_idx]     <= 1'b1;
                        r_restart[w_target_idx]    <= 1'b1;
                        r_stamp[w_target_idx]      <= r_stamp_ctr;
                        r_stamp_ctr                <= r_stamp_ctr + 1'b1;
                    end else if (r_on) begin
                        r_drop <= 1'b1;
                    end else if (w_match_found) begin
                        r_voice_note[w_match_idx] <= NOTE_SILENT;
                        r_active[w_match_idx]     <= 1'b0;
                    end
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign event_ready_out   = r_ready;
    assign voice_note_out    = r_voice_note;
    assign voice_active_out  = r_active;
    assign voice_restart_out = r_restart;
    assign drop_out          = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module : tb_voice_allocator
// Scoreboard bench for voice_allocator; honours VOICE_STEAL_EN like the DUT.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_voice_allocator;

    localparam int N  = 4;
    localparam int SW = 16;

    logic           clk_in = 1'b0;
    logic           rst_in = 1'b0;
    logic           event_valid_in = 1'b0;
    logic           event_on_in = 1'b0;
    logic [7:0]     event_note_in = 8'd0;
    logic           event_ready_out;
    logic [8*N-1:0] voice_note_out;
    logic [N-1:0]   voice_active_out;
    logic [N-1:0]   voice_restart_out;
    logic           drop_out;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    voice_allocator #(.NUM_VOICES(N), .STAMP_W(SW)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .event_valid_in    (event_valid_in),
        .event_ready_out   (event_ready_out),
        .event_on_in       (event_on_in),
        .event_note_in     (event_note_in),
        .voice_note_out    (voice_note_out),
        .voice_active_out  (voice_active_out),
        .voice_restart_out (voice_restart_out),
        .drop_out          (drop_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [8*N-1:0] notes;
        logic [N-1:0]   act;
        logic [N-1:0]   rst_p;
        logic           drop;
    } exp_t;

    exp_t sb[$];

    // Reference model of the allocation policy
    logic [7:0]    m_note  [N];
    logic          m_act   [N];
    logic [SW-1:0] m_stamp [N];
    logic [SW-1:0] m_ctr;

    logic [8*N-1:0] obs_notes;
    logic [N-1:0]   obs_act;
    logic [N-1:0]   obs_restart;
    logic           obs_drop;
    int             obs_lowcnt;
    int             acc_cyc;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_note[i]  = 8'd0;
            m_act[i]   = 1'b0;
            m_stamp[i] = '0;
        end
        m_ctr = '0;
    endfunction

    function automatic exp_t model_step(input logic on, input logic [7:0] note);
        exp_t          e;
        int            mi = -1;
        int            fi = -1;
        int            oi = -1;
        int            t  = -1;
        logic [SW-1:0] best = '0;
        logic [SW-1:0] age;
        for (int i = 0; i < N; i++) begin
            if (m_act[i] && m_note[i] == note && mi < 0) mi = i;
            if (!m_act[i] && fi < 0) fi = i;
            age = m_ctr - m_stamp[i];
            if (m_act[i] && (oi < 0 || age > best)) begin
                oi   = i;
                best = age;
            end
        end
        e.rst_p = '0;
        e.drop  = 1'b0;
        if (on) begin
            if (mi >= 0) t = mi;
            else if (fi >= 0) t = fi;
            else begin
`ifdef VOICE_STEAL_EN
                t = oi;
`else
                e.drop = 1'b1;
`endif
            end
            if (t >= 0) begin
                m_note[t]  = note;
                m_act[t]   = 1'b1;
                m_stamp[t] = m_ctr;
                m_ctr      = m_ctr + 1'b1;
                e.rst_p[t] = 1'b1;
            end
        end else if (mi >= 0) begin
            m_note[mi] = 8'd0;
            m_act[mi]  = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            e.notes[8*i +: 8] = m_note[i];
            e.act[i]          = m_act[i];
        end
        return e;
    endfunction

    task automatic do_reset();
        rst_in = 1'b0;
        event_valid_in = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        model_reset();
        sb.delete();
    endtask

    // Drives one event, pushes its prediction, and scores the commit cycle.
    task automatic run_event(input logic on, input logic [7:0] note);
        int   w;
        exp_t e;
        w = 0;
        while (event_ready_out !== 1'b1 && w < 50) begin
            @(posedge clk_in); #1;
            w++;
        end
        n_tests++;
        if (w >= 50) begin
            n_fail++;
            $display("FAIL ready_wait: ready=%b required 1", event_ready_out);
        end
        event_valid_in = 1'b1;
        event_on_in    = on;
        event_note_in  = note;
        sb.push_back(model_step(on, note));
        @(posedge clk_in); #1;
        acc_cyc = cyc;
        // Garbage held valid while busy must be ignored
        event_on_in   = 1'($urandom_range(0, 1));
        event_note_in = 8'($urandom);
        obs_lowcnt = 0;
        while (event_ready_out !== 1'b1 && obs_lowcnt < 50) begin
            obs_lowcnt++;
            @(posedge clk_in); #1;
        end
        event_valid_in = 1'b0;
        obs_notes   = voice_note_out;
        obs_act     = voice_active_out;
        obs_restart = voice_restart_out;
        obs_drop    = drop_out;
        e = sb.pop_front();
        n_tests++;
        if (obs_lowcnt != N + 1) begin
            n_fail++;
            $display("FAIL sb_busy_cycles: got %0d required %0d", obs_lowcnt, N + 1);
        end
        n_tests++;
        if (obs_notes !== e.notes) begin
            n_fail++;
            $display("FAIL sb_notes: got %h required %h", obs_notes, e.notes);
        end
        n_tests++;
        if (obs_act !== e.act) begin
            n_fail++;
            $display("FAIL sb_active: got %b required %b", obs_act, e.act);
        end
        n_tests++;
        if (obs_restart !== e.rst_p) begin
            n_fail++;
            $display("FAIL sb_restart: got %b required %b", obs_restart, e.rst_p);
        end
        n_tests++;
        if (obs_drop !== e.drop) begin
            n_fail++;
            $display("FAIL sb_drop: got %b required %b", obs_drop, e.drop);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        event_valid_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        n_tests++;
        if (voice_note_out !== '0) begin n_fail++; $display("FAIL reset_notes: got %h required 0", voice_note_out); end
        n_tests++;
        if (voice_active_out !== '0) begin n_fail++; $display("FAIL reset_active: got %b required 0", voice_active_out); end
        n_tests++;
        if (voice_restart_out !== '0) begin n_fail++; $display("FAIL reset_restart: got %b required 0", voice_restart_out); end
        n_tests++;
        if (drop_out !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b required 0", drop_out); end
        n_tests++;
        if (event_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", event_ready_out); end
        rst_in = 1'b1;
        model_reset();
    endtask

    task automatic test_first_note();
        run_event(1'b1, 8'd60);
        n_tests++;
        if (obs_notes[7:0] !== 8'd60) begin n_fail++; $display("FAIL first_note_v0: got %0d required 60", obs_notes[7:0]); end
        n_tests++;
        if (obs_act !== 4'b0001) begin n_fail++; $display("FAIL first_note_active: got %b required 0001", obs_act); end
        n_tests++;
        if (obs_restart !== 4'b0001) begin n_fail++; $display("FAIL first_note_restart: got %b required 0001", obs_restart); end
        @(posedge clk_in); #1;
        n_tests++;
        if (voice_restart_out !== 4'b0000) begin n_fail++; $display("FAIL restart_one_cycle: got %b required 0000", voice_restart_out); end
    endtask

    task automatic test_note_off();
        do_reset();
        run_event(1'b1, 8'd60);
        run_event(1'b1, 8'd62);
        run_event(1'b1, 8'd64);
        run_event(1'b0, 8'd62);
        n_tests++;
        if (obs_notes[15:8] !== 8'd0) begin n_fail++; $display("FAIL off_v1_note: got %0d required 0", obs_notes[15:8]); end
        n_tests++;
        if (obs_act !== 4'b0101) begin n_fail++; $display("FAIL off_active: got %b required 0101", obs_act); end
        n_tests++;
        if (obs_restart !== 4'b0000) begin n_fail++; $display("FAIL off_restart: got %b required 0000", obs_restart); end
        run_event(1'b1, 8'd67);
        n_tests++;
        if (obs_notes[15:8] !== 8'd67) begin n_fail++; $display("FAIL refill_v1_note: got %0d required 67", obs_notes[15:8]); end
        n_tests++;
        if (obs_act !== 4'b0111) begin n_fail++; $display("FAIL refill_active: got %b required 0111", obs_act); end
    endtask

    task automatic test_retrigger();
        do_reset();
        run_event(1'b1, 8'd60);
        run_event(1'b1, 8'd60);
        n_tests++;
        if (obs_restart !== 4'b0001) begin n_fail++; $display("FAIL retrig_restart: got %b required 0001", obs_restart); end
        n_tests++;
        if (obs_act !== 4'b0001) begin n_fail++; $display("FAIL retrig_active: got %b required 0001", obs_act); end
    endtask

    task automatic test_full();
        do_reset();
        run_event(1'b1, 8'd60);
        run_event(1'b1, 8'd62);
        run_event(1'b1, 8'd64);
        run_event(1'b1, 8'd65);
        run_event(1'b1, 8'd72);
`ifdef VOICE_STEAL_EN
        n_tests++;
        if (obs_notes !== {8'd65, 8'd64, 8'd62, 8'd72}) begin n_fail++; $display("FAIL steal_notes: got %h required 41403e48", obs_notes); end
        n_tests++;
        if (obs_drop !== 1'b0 || obs_restart !== 4'b0001) begin n_fail++; $display("FAIL steal_pulses: got drop=%b restart=%b required drop=0 restart=0001", obs_drop, obs_restart); end
`else
        n_tests++;
        if (obs_notes !== {8'd65, 8'd64, 8'd62, 8'd60}) begin n_fail++; $display("FAIL drop_notes: got %h required 41403e3c", obs_notes); end
        n_tests++;
        if (obs_drop !== 1'b1 || obs_restart !== 4'b0000) begin n_fail++; $display("FAIL drop_pulses: got drop=%b restart=%b required drop=1 restart=0000", obs_drop, obs_restart); end
`endif
        @(posedge clk_in); #1;
        n_tests++;
        if (drop_out !== 1'b0) begin n_fail++; $display("FAIL drop_one_cycle: got %b required 0", drop_out); end
    endtask

    task automatic test_off_idle();
        run_event(1'b0, 8'd71);
        n_tests++;
        if (obs_lowcnt != N + 1) begin n_fail++; $display("FAIL off_idle_busy: got %0d required %0d", obs_lowcnt, N + 1); end
`ifdef VOICE_STEAL_EN
        n_tests++;
        if (obs_notes !== {8'd65, 8'd64, 8'd62, 8'd72}) begin n_fail++; $display("FAIL off_idle_notes: got %h required 41403e48", obs_notes); end
`else
        n_tests++;
        if (obs_notes !== {8'd65, 8'd64, 8'd62, 8'd60}) begin n_fail++; $display("FAIL off_idle_notes: got %h required 41403e3c", obs_notes); end
`endif
        n_tests++;
        if (obs_act !== 4'b1111) begin n_fail++; $display("FAIL off_idle_active: got %b required 1111", obs_act); end
    endtask

    task automatic test_back_to_back();
        int a1;
        do_reset();
        run_event(1'b1, 8'd0);
        a1 = acc_cyc;
        n_tests++;
        if (obs_act !== 4'b0001 || obs_notes[7:0] !== 8'd0) begin n_fail++; $display("FAIL note0_on: got act=%b v0=%0d required act=0001 v0=0", obs_act, obs_notes[7:0]); end
        run_event(1'b1, 8'd5);
        n_tests++;
        if (acc_cyc - a1 != N + 2) begin n_fail++; $display("FAIL b2b_spacing: got %0d required %0d", acc_cyc - a1, N + 2); end
        run_event(1'b0, 8'd0);
        n_tests++;
        if (obs_act !== 4'b0010 || obs_notes[15:8] !== 8'd5) begin n_fail++; $display("FAIL note0_off: got act=%b v1=%0d required act=0010 v1=5", obs_act, obs_notes[15:8]); end
    endtask

    task automatic test_reset_mid_scan();
        logic [N-1:0] seen;
        do_reset();
        run_event(1'b1, 8'd60);
        run_event(1'b1, 8'd62);
        event_valid_in = 1'b1;
        event_on_in    = 1'b1;
        event_note_in  = 8'd64;
        @(posedge clk_in); #1;
        event_valid_in = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        n_tests++;
        if (voice_note_out !== '0 || voice_active_out !== '0) begin n_fail++; $display("FAIL midscan_clear: got notes=%h act=%b required 0", voice_note_out, voice_active_out); end
        n_tests++;
        if (event_ready_out !== 1'b1 || voice_restart_out !== '0 || drop_out !== 1'b0) begin n_fail++; $display("FAIL midscan_ctrl: got ready=%b restart=%b drop=%b required 1/0/0", event_ready_out, voice_restart_out, drop_out); end
        rst_in = 1'b1;
        model_reset();
        seen = '0;
        repeat (N + 3) begin
            @(posedge clk_in); #1;
            seen = seen | voice_active_out | voice_restart_out;
        end
        n_tests++;
        if (seen !== '0) begin n_fail++; $display("FAIL midscan_lost: got %b required 0", seen); end
        run_event(1'b1, 8'd67);
        n_tests++;
        if (obs_notes[7:0] !== 8'd67 || obs_act !== 4'b0001) begin n_fail++; $display("FAIL midscan_recover: got v0=%0d act=%b required 67/0001", obs_notes[7:0], obs_act); end
    endtask

    initial begin
        test_reset();
        test_first_note();
        test_note_off();
        test_retrigger();
        test_full();
        test_off_idle();
        test_back_to_back();
        test_reset_mid_scan();
        n_tests++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d required 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
